// File: rtl/data_ram_ctrl_if.sv
// Request/response bus of the load/store data RAM controller.
// The master drives requests and the clear pulse; the slave (the RAM
// controller) returns the handshake, the registered response and busy.
interface data_ram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  clear_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [DATA_W/8-1:0]   req_be_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic                  rsp_valid_o;
    logic [DATA_W-1:0]     rsp_data_o;
    logic                  rsp_err_o;
    logic                  busy_o;

    modport master (
        output clear_i, req_valid_i, req_we_i, req_be_i, addr_i, data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
    );

    modport slave (
        input  clear_i, req_valid_i, req_we_i, req_be_i, addr_i, data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/data_ram_ctrl.sv
// Single-port data RAM for the load/store path.
// Requests use a valid/ready handshake; every accepted request yields a
// one-cycle registered response one cycle later. Misaligned and
// out-of-range accesses are flagged and never touch the array. A clear
// sequence zeroes one word per cycle after reset or on request.
module data_ram_ctrl #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4096,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    data_ram_ctrl_if.slave     bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int UP_W  = ADDR_W - OFF - IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // Expand per-byte enables into a per-bit write mask.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

    // Storage has no reset; contents are defined only by clear or writes.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              misaligned_s;
    logic              out_of_range_s;
    logic              err_s;
    logic [IDX_W-1:0]  idx_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] wmask_s;

    // Byte-offset bits only exist when a word holds more than one byte.
    generate
        if (OFF > 0) begin : g_align
            assign misaligned_s = |bus.addr_i[OFF-1:0];
        end else begin : g_no_align
            assign misaligned_s = 1'b0;
        end
    endgenerate

    // Address bits above the word index select words beyond DEPTH.
    generate
        if (UP_W > 0) begin : g_range
            assign out_of_range_s = |bus.addr_i[ADDR_W-1:OFF+IDX_W];
        end else begin : g_no_range
            assign out_of_range_s = 1'b0;
        end
    endgenerate

    assign idx_s       = bus.addr_i[OFF +: IDX_W];
    assign err_s       = misaligned_s | out_of_range_s;
    assign req_ready_s = (state_q == ST_IDLE) && !bus.clear_i;
    assign accept_s    = bus.req_valid_i && req_ready_s;
    assign wr_en_s     = accept_s && bus.req_we_i && !err_s;
    assign wmask_s     = be_to_mask(bus.req_be_i);

    // Array writes: one zeroed word per clear cycle, else masked request data.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en_s) begin
            mem_q[idx_s] <= (mem_q[idx_s] & ~wmask_s) | (bus.data_i & wmask_s);
        end
    end

    // Next-state and response computation for the clear/serve controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_IDX;
                end
            end
            ST_IDLE: begin
                if (bus.clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
                if (accept_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    if (!bus.req_we_i && !err_s) begin
                        rsp_data_d = mem_q[idx_s];
                    end else begin
                        rsp_data_d = '0;
                    end
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready_o = req_ready_s;
    assign bus.busy_o      = (state_q == ST_CLEAR);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: a default 32-bit/4096-word instance and a
// 64-bit/16-word instance. Vector tables give expected responses, which
// are queued with their due cycle and compared by per-instance monitors.
module tb_data_ram_ctrl;

    typedef struct {
        logic        we;
        logic [7:0]  be;
        logic [31:0] addr;
        logic [63:0] data;
        logic        err;
        logic [63:0] rdata;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    logic clk;
    logic rst0;
    logic rst1;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e0;
    exp_t e1;
    vec_t tab0 [16];
    vec_t tab1 [7];

    data_ram_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
    data_ram_ctrl_if #(.DATA_W(64), .ADDR_W(32)) if1 ();

    data_ram_ctrl #(.DATA_W(32), .DEPTH(4096), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    data_ram_ctrl #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] be, input logic [31:0] addr,
                                input logic [63:0] data, input logic err, input logic [63:0] rdata);
        vec_t v;
        v.we = we; v.be = be; v.addr = addr; v.data = data; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // Response monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e0 = q0.pop_front();
            chk("rsp0_valid", {63'd0, if0.rsp_valid_o}, 64'd1);
            chk("rsp0_err",   {63'd0, if0.rsp_err_o}, {63'd0, e0.err});
            chk("rsp0_data",  {32'd0, if0.rsp_data_o}, e0.rdata);
        end else begin
            chk("rsp0_quiet", {63'd0, if0.rsp_valid_o}, 64'd0);
        end
    end

    // Response monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e1 = q1.pop_front();
            chk("rsp1_valid", {63'd0, if1.rsp_valid_o}, 64'd1);
            chk("rsp1_err",   {63'd0, if1.rsp_err_o}, {63'd0, e1.err});
            chk("rsp1_data",  if1.rsp_data_o, e1.rdata);
        end else begin
            chk("rsp1_quiet", {63'd0, if1.rsp_valid_o}, 64'd0);
        end
    end

    // Present one request (called just after a rising edge); it is accepted
    // at the next rising edge and its response is due one cycle later.
    task automatic drive(input int d, input vec_t v);
        exp_t e;
        e.due   = cyc + 1;
        e.err   = v.err;
        e.rdata = v.rdata;
        if (d == 0) begin
            if0.req_valid_i = 1'b1; if0.req_we_i = v.we; if0.req_be_i = v.be[3:0];
            if0.addr_i = v.addr; if0.data_i = v.data[31:0];
            q0.push_back(e);
        end else begin
            if1.req_valid_i = 1'b1; if1.req_we_i = v.we; if1.req_be_i = v.be;
            if1.addr_i = v.addr; if1.data_i = v.data;
            q1.push_back(e);
        end
        @(negedge clk);
        if (d == 0) chk("ready0", {63'd0, if0.req_ready_o}, 64'd1);
        else        chk("ready1", {63'd0, if1.req_ready_o}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        if0.req_valid_i = 1'b0; if0.clear_i = 1'b0;
        if1.req_valid_i = 1'b0; if1.clear_i = 1'b0;
    endtask

    // Count negedges with busy high; optionally pulse clear_i at count poke.
    task automatic count_busy(input int d, input int poke, output int n);
        logic b;
        logic rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        @(negedge clk);
        b = (d == 0) ? if0.busy_o : if1.busy_o;
        while (b && n < 6000) begin
            n++;
            if ((d == 0 ? if0.req_ready_o : if1.req_ready_o) == 1'b1) rdy_seen = 1'b1;
            if (d == 0) if0.clear_i = (n == poke);
            else        if1.clear_i = (n == poke);
            @(negedge clk);
            b = (d == 0) ? if0.busy_o : if1.busy_o;
        end
        if0.clear_i = 1'b0;
        if1.clear_i = 1'b0;
        chk("ready_low_while_busy", {63'd0, rdy_seen}, 64'd0);
        chk("ready_after_clear", {63'd0, (d == 0 ? if0.req_ready_o : if1.req_ready_o)}, 64'd1);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.clear_i = 1'b0; if0.req_valid_i = 1'b0; if0.req_we_i = 1'b0;
        if0.req_be_i = 4'h0; if0.addr_i = 32'h0; if0.data_i = 32'h0;
        if1.clear_i = 1'b0; if1.req_valid_i = 1'b0; if1.req_we_i = 1'b0;
        if1.req_be_i = 8'h0; if1.addr_i = 32'h0; if1.data_i = 64'h0;

        tab0[0]  = mk(1'b0, 8'h0, 32'h3FFC, 64'h0, 1'b0, 64'h0);
        tab0[1]  = mk(1'b1, 8'hF, 32'h10, 64'h11223344, 1'b0, 64'h0);
        tab0[2]  = mk(1'b1, 8'h5, 32'h10, 64'hAABBCCDD, 1'b0, 64'h0);
        tab0[3]  = mk(1'b0, 8'h0, 32'h10, 64'h0, 1'b0, 64'h11BB33DD);
        tab0[4]  = mk(1'b1, 8'h0, 32'h10, 64'hFFFFFFFF, 1'b0, 64'h0);
        tab0[5]  = mk(1'b0, 8'h0, 32'h10, 64'h0, 1'b0, 64'h11BB33DD);
        tab0[6]  = mk(1'b1, 8'hF, 32'h12, 64'hDEADBEEF, 1'b1, 64'h0);
        tab0[7]  = mk(1'b1, 8'hF, 32'h4000, 64'hDEADBEEF, 1'b1, 64'h0);
        tab0[8]  = mk(1'b0, 8'h0, 32'h10, 64'h0, 1'b0, 64'h11BB33DD);
        tab0[9]  = mk(1'b0, 8'h0, 32'h0, 64'h0, 1'b0, 64'h0);
        tab0[10] = mk(1'b0, 8'h0, 32'h4000, 64'h0, 1'b1, 64'h0);
        tab0[11] = mk(1'b0, 8'h0, 32'h11, 64'h0, 1'b1, 64'h0);
        tab0[12] = mk(1'b0, 8'h0, 32'hFFFFFFFC, 64'h0, 1'b1, 64'h0);
        tab0[13] = mk(1'b0, 8'h0, 32'h10, 64'h0, 1'b0, 64'h11BB33DD);
        tab0[14] = mk(1'b1, 8'hF, 32'h3FFC, 64'hCAFEF00D, 1'b0, 64'h0);
        tab0[15] = mk(1'b0, 8'h0, 32'h3FFC, 64'h0, 1'b0, 64'hCAFEF00D);

        tab1[0] = mk(1'b0, 8'h00, 32'h04, 64'h0, 1'b1, 64'h0);
        tab1[1] = mk(1'b1, 8'hFF, 32'h80, 64'h5555, 1'b1, 64'h0);
        tab1[2] = mk(1'b0, 8'h00, 32'h80, 64'h0, 1'b1, 64'h0);
        tab1[3] = mk(1'b1, 8'hF0, 32'h78, 64'h0123456789ABCDEF, 1'b0, 64'h0);
        tab1[4] = mk(1'b0, 8'h00, 32'h78, 64'h0, 1'b0, 64'h0123456700000000);
        tab1[5] = mk(1'b0, 8'h00, 32'h00, 64'h0, 1'b0, 64'h0);
        tab1[6] = mk(1'b1, 8'hFF, 32'h100, 64'h1, 1'b1, 64'h0);

        // Reset state of the default instance.
        repeat (3) @(negedge clk);
        chk("rst_busy0",  {63'd0, if0.busy_o}, 64'd1);
        chk("rst_ready0", {63'd0, if0.req_ready_o}, 64'd0);
        chk("rst_data0",  {32'd0, if0.rsp_data_o}, 64'd0);
        chk("rst_err0",   {63'd0, if0.rsp_err_o}, 64'd0);

        // Clear after reset release lasts DEPTH cycles.
        @(posedge clk); #1;
        rst0 = 1'b0;
        count_busy(0, -1, n);
        chk("clear_len_reset", n, 64'd4096);

        // Vector table: byte enables, errors, boundary addresses.
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) drive(0, tab0[i]);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("hold_data0", {32'd0, if0.rsp_data_o}, 64'hCAFEF00D);
        chk("hold_err0",  {63'd0, if0.rsp_err_o}, 64'd0);

        // Streaming write/read pairs on consecutive cycles.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'h20 + 32'(4 * i);
            drive(0, mk(1'b1, 8'hF, a, {32'd0, a + 32'd1}, 1'b0, 64'h0));
            drive(0, mk(1'b0, 8'h0, a, 64'h0, 1'b0, {32'd0, a + 32'd1}));
        end
        idle();

        // clear_i with a valid request: request refused, clear wins;
        // a second clear_i mid-sequence must not restart it.
        @(posedge clk); #1;
        if0.clear_i = 1'b1; if0.req_valid_i = 1'b1; if0.req_we_i = 1'b0; if0.addr_i = 32'h10;
        @(negedge clk);
        chk("clear_refuses_req", {63'd0, if0.req_ready_o}, 64'd0);
        @(posedge clk); #1;
        idle();
        count_busy(0, 50, n);
        chk("clear_len_req", n, 64'd4096);
        @(posedge clk); #1;
        drive(0, mk(1'b0, 8'h0, 32'h10, 64'h0, 1'b0, 64'h0));
        drive(0, mk(1'b0, 8'h0, 32'h24, 64'h0, 1'b0, 64'h0));
        drive(0, mk(1'b0, 8'h0, 32'h3FFC, 64'h0, 1'b0, 64'h0));
        idle();

        // Reset at clear cycle 100 restarts the full sequence.
        @(posedge clk); #1;
        if0.clear_i = 1'b1;
        @(posedge clk); #1;
        if0.clear_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(negedge clk);
        chk("midclear_rst_busy", {63'd0, if0.busy_o}, 64'd1);
        @(posedge clk); #1;
        rst0 = 1'b0;
        count_busy(0, -1, n);
        chk("clear_len_restart", n, 64'd4096);

        // 64-bit, 16-word instance.
        chk("rst_busy1",  {63'd0, if1.busy_o}, 64'd1);
        chk("rst_data1",  if1.rsp_data_o, 64'd0);
        @(posedge clk); #1;
        rst1 = 1'b0;
        count_busy(1, -1, n);
        chk("clear_len_small", n, 64'd16);
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) drive(1, tab1[i]);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("hold_err1",  {63'd0, if1.rsp_err_o}, 64'd1);
        chk("hold_data1", if1.rsp_data_o, 64'd0);

        repeat (2) @(negedge clk);
        chk("q0_drained", q0.size(), 64'd0);
        chk("q1_drained", q1.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
